axis_line_buffer: RTL and testbench

//  Upstream of the unpack/FIFO and PE stages. Takes a raster pixel stream, one pixel per beat, and emits one

---
 rtl/axis_line_buffer.sv | 152 +++++++++++++++
 tb/tb_axis_line_buffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_line_buffer
//  Description : Raster pixel stream in, KERNEL_SIZE-tall column vectors out.
//                Each output vector holds the accepted pixel plus the pixels
//                from the same column of the KERNEL_SIZE-1 preceding rows.
//                The first KERNEL_SIZE-1 rows of each frame only fill the line
//                memories. No vectors are emitted for those rows.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_line_buffer #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast
);

    localparam int c_col_w = $clog2(IMG_WIDTH);
    localparam int c_row_w = $clog2(IMG_HEIGHT);
    localparam int c_vec_w = KERNEL_SIZE * DATA_WIDTH;

    localparam logic [c_col_w-1:0] c_last_col  = c_col_w'(IMG_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_last_row  = c_row_w'(IMG_HEIGHT - 1);
    localparam logic [c_row_w-1:0] c_fill_row  = c_row_w'(KERNEL_SIZE - 2);

    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_load;

    logic [c_col_w-1:0]     r_col;
    logic [c_row_w-1:0]     r_row;

    // Line 0 is the oldest row and line KERNEL_SIZE-2 is the newest.
    logic [DATA_WIDTH-1:0]  r_line [KERNEL_SIZE-1][IMG_WIDTH];

    logic [c_vec_w-1:0]     r_tdata;
    logic                   r_tvalid;
    logic                   r_tlast;

    logic                   w_s_ready;
    logic                   w_accept;
    logic                   w_end_col;
    logic                   w_end_row;
    logic [c_vec_w-1:0]     w_vec;

    assign w_s_ready = ~r_tvalid | m_axis_tready;
    assign w_accept  = s_axis_tvalid & w_s_ready;
    assign w_end_col = (r_col == c_last_col);
    assign w_end_row = (r_row == c_last_row);

    assign s_axis_tready = w_s_ready;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;

    // Older lanes come from the line memories before this cycle's shift.
    // The newest lane is the live input pixel.
    for (genvar k = 0; k < KERNEL_SIZE - 1; k++) begin : g_lane
        assign w_vec[k*DATA_WIDTH +: DATA_WIDTH] = r_line[k][r_col];
    end
    assign w_vec[(KERNEL_SIZE-1)*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;

    // Column and row position of the next pixel within the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_end_col) begin
                r_col <= '0;
                r_row <= w_end_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Shift the current column up by one line and insert the new pixel.
    // The line memories are not reset. FILL rewrites them before any read is emitted.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int j = 0; j < KERNEL_SIZE - 2; j++) begin
                r_line[j][r_col] <= r_line[j+1][r_col];
            end
            r_line[KERNEL_SIZE-2][r_col] <= s_axis_tdata;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FILL lasts until the lines hold KERNEL_SIZE-1 rows. STREAM then runs to the end of the frame.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_accept && w_end_col && (r_row == c_fill_row)) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_load = w_accept;
                if (w_accept && w_end_col && w_end_row) begin
                    w_state_next = ST_FILL;
                end
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    // Output register. A load takes priority over a plain emit, so a
    // simultaneous emit and accept keeps valid high with the new vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else if (w_load) begin
            r_tdata  <= w_vec;
            r_tlast  <= w_end_col;
            r_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_line_buffer
//  Description : Self-checking bench for axis_line_buffer (K=3, W=4, H=4).
//                A frame-image reference model pushes expected vectors.
//                A separate monitor pops them and compares them on every emit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_line_buffer;

    localparam int K  = 3;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    typedef struct packed {
        logic          last;
        logic [K*DW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [K*DW-1:0] m_data;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic            m_last;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int stalls = 0;
    int emit_count = 0;
    int last_count = 0;
    int rdy_mode = 0;

    exp_t          q[$];
    logic [DW-1:0] frame [H][W];
    int            n_acc = 0;

    axis_line_buffer #(
        .KERNEL_SIZE (K),
        .DATA_WIDTH  (DW),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tlast  (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return DW'(r * 16 + c);
    endfunction

    // Reference model. It records the frame by raster position and computes each
    // vector from the rows above it in the same frame.
    always @(negedge clk) begin : p_model
        int   idx, r, c;
        exp_t e;
        if (rst) begin
            q.delete();
            n_acc = 0;
        end else if (s_valid && s_ready) begin
            idx = n_acc % (W * H);
            r   = idx / W;
            c   = idx % W;
            frame[r][c] = s_data;
            if (r >= K - 1) begin
                e.data = '0;
                for (int j = 0; j < K; j++) begin
                    e.data[j*DW +: DW] = frame[r-(K-1)+j][c];
                end
                e.last = (c == W - 1);
                q.push_back(e);
            end
            n_acc++;
        end
    end

    // Monitor: the handshake completes at the next rising edge.
    always @(negedge clk) begin : p_monitor
        exp_t e;
        if (!rst && m_valid && m_ready) begin
            emit_count++;
            if (m_last) last_count++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vector: got 0x%0h expected none", m_data);
            end else begin
                e = q.pop_front();
                chk("vector_data", 32'(m_data), 32'(e.data));
                chk("vector_last", 32'(m_last), 32'(e.last));
            end
        end
    end

    // Downstream ready: 0 = always, 1 = random, 2 = stalled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [DW-1:0] d, input int gap);
        int waited;
        bit ok;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        waited  = 0;
        forever begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            stalls++;
            if (waited > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: pixel 0x%0h not accepted after %0d cycles", d, waited);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(q.size()), 32'd0);
    endtask

    initial begin : p_stim
        int c0, e0, l0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tvalid", 32'(m_valid), 32'd0);
        chk("reset_tdata",  32'(m_data),  32'd0);
        chk("reset_tlast",  32'(m_last),  32'd0);
        chk("reset_tready", 32'(s_ready), 32'd1);
        rst = 1'b0;

        // Fill: rows 0-1 give no output, input never stalls
        stalls = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) send(pix(r, c), 0);
        chk("fill_tvalid", 32'(m_valid), 32'd0);
        chk("fill_stalls", 32'(stalls), 32'd0);

        // First vectors and full throughput over rows 2-3
        stalls = 0;
        c0 = cycle;
        e0 = emit_count;
        for (int r = 2; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(pix(r, c), 0);
                if (r == 2 && c == 0) begin
                    chk("first_tvalid", 32'(m_valid), 32'd1);
                    chk("first_tdata",  32'(m_data),  32'h201000);
                    chk("first_tlast",  32'(m_last),  32'd0);
                end
                if (r == 2 && c == W - 1) begin
                    chk("row2_end_tdata", 32'(m_data), 32'h231303);
                    chk("row2_end_tlast", 32'(m_last), 32'd1);
                end
                if (r == H - 1 && c == W - 1) begin
                    chk("frame_end_tdata", 32'(m_data), 32'h332313);
                    chk("frame_end_tlast", 32'(m_last), 32'd1);
                end
            end
        end
        chk("stream_cycles", 32'(cycle - c0), 32'd8);
        chk("stream_stalls", 32'(stalls), 32'd0);
        @(posedge clk);
        #1;
        chk("stream_vectors", 32'(emit_count - e0), 32'd8);

        // Next frame rows 0-1 produce nothing
        e0 = emit_count;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) send(pix(r, c), 0);
        @(posedge clk);
        #1;
        chk("refill_vectors", 32'(emit_count - e0), 32'd0);
        chk("refill_tvalid",  32'(m_valid), 32'd0);

        // Backpressure with a vector pending
        rdy_mode = 2;
        send(pix(2, 0), 0);
        s_valid = 1'b1;
        s_data  = pix(2, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_s_tready", 32'(s_ready), 32'd0);
            chk("bp_tvalid",   32'(m_valid), 32'd1);
            chk("bp_tdata",    32'(m_data),  32'h201000);
            chk("bp_tlast",    32'(m_last),  32'd0);
            @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        send(pix(2, 1), 0);
        for (int r = 2; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r > 2 || c > 1) send(pix(r, c), 0);
        drain("bp_drain");

        // Reset in the middle of a frame
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) send(pix(r, c), 0);
        send(pix(2, 0), 0);
        send(pix(2, 1), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tvalid", 32'(m_valid), 32'd0);
        chk("midrst_tdata",  32'(m_data),  32'd0);
        chk("midrst_tlast",  32'(m_last),  32'd0);
        chk("midrst_tready", 32'(s_ready), 32'd1);
        rst = 1'b0;
        e0 = emit_count;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) send(pix(r, c), 0);
        chk("rst_fill_tvalid", 32'(m_valid), 32'd0);
        send(pix(2, 0), 0);
        chk("rst_first_tvalid", 32'(m_valid), 32'd1);
        chk("rst_first_tdata",  32'(m_data),  32'h201000);
        for (int r = 2; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r > 2 || c > 0) send(pix(r, c), 0);
        drain("rst_drain");
        chk("rst_vectors", 32'(emit_count - e0), 32'd8);

        // Random data, gaps and backpressure over 3 frames
        rdy_mode = 1;
        e0 = emit_count;
        l0 = last_count;
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < W * H; p++) send(DW'($urandom), $urandom_range(0, 2));
        drain("rand_drain");
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("rand_vectors", 32'(emit_count - e0), 32'd24);
        chk("rand_tlast",   32'(last_count - l0), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
